// File: rtl/nonce_search_ctrl.sv
// Mining-loop sequencer: launches hashes, compares digests against the target, steps the nonce.
// Optional watchdog on the hash wait is enabled by defining HASH_TIMEOUT_EN.
module nonce_search_ctrl #(
  parameter int NONCE_W        = 32,
  parameter int HASH_W         = 256,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start_search,
  input  logic               stop_search,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [HASH_W-1:0]  target,
  input  logic               hash_done,
  input  logic [HASH_W-1:0]  hash_value,
  output logic               begin_hash,
  output logic               quit_hash,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [CNT_W-1:0]   attempt_cnt,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HASH,
    COMPARE,
    FOUND,
    EXHAUSTED
  } state_t;

  state_t             state, state_next;
  logic [NONCE_W-1:0] nonce_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [HASH_W-1:0]  digest, digest_next;
  logic               wd_fire;

`ifdef HASH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside WAIT_HASH, so every entry into the wait starts a fresh count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      wd_cnt <= '0;
    else if (state != WAIT_HASH)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_fire = (state == WAIT_HASH) && (wd_cnt == WD_W'(TIMEOUT_CYCLES));
`else
  // Watchdog absent: this expression is constant 0.
  assign wd_fire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      nonce       <= '0;
      attempt_cnt <= '0;
      digest      <= '0;
    end else begin
      state       <= state_next;
      nonce       <= nonce_next;
      attempt_cnt <= cnt_next;
      digest      <= digest_next;
    end
  end

  always_comb begin
    state_next  = state;
    nonce_next  = nonce;
    cnt_next    = attempt_cnt;
    digest_next = digest;
    begin_hash  = 1'b0;
    quit_hash   = 1'b0;
    timeout_err = 1'b0;

    unique case (state)
      IDLE, FOUND, EXHAUSTED: begin
        if (stop_search) begin
          state_next = IDLE;
        end else if (start_search) begin
          nonce_next = nonce_base;
          cnt_next   = '0;
          state_next = LAUNCH;
        end
      end

      LAUNCH: begin
        if (stop_search) begin
          quit_hash  = 1'b1;
          state_next = IDLE;
        end else begin
          begin_hash = 1'b1;
          state_next = WAIT_HASH;
        end
      end

      WAIT_HASH: begin
        if (stop_search) begin
          quit_hash  = 1'b1;
          state_next = IDLE;
        end else if (hash_done) begin
          digest_next = hash_value;
          state_next  = COMPARE;
        end else if (wd_fire) begin
          quit_hash   = 1'b1;
          timeout_err = 1'b1;
          state_next  = LAUNCH;
        end
      end

      COMPARE: begin
        if (stop_search) begin
          quit_hash  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = (&attempt_cnt) ? attempt_cnt : attempt_cnt + 1'b1;
          if (digest < target)
            state_next = FOUND;
          else if (&nonce)
            state_next = EXHAUSTED;
          else begin
            nonce_next = nonce + 1'b1;
            state_next = LAUNCH;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == LAUNCH) || (state == WAIT_HASH) || (state == COMPARE);
  assign found     = (state == FOUND);
  assign exhausted = (state == EXHAUSTED);

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Self-checking bench for nonce_search_ctrl: directed scenarios plus randomized searches
// checked against a first-winning-digest model.
module tb_nonce_search_ctrl;

  localparam int NW = 32;
  localparam int HW = 256;
  localparam int CW = 32;

  typedef logic [HW-1:0] dig_q_t[$];
  typedef logic [NW-1:0] nonce_q_t[$];

  logic          clk;
  logic          n_rst;
  logic          start_search;
  logic          stop_search;
  logic [NW-1:0] nonce_base;
  logic [HW-1:0] target;
  logic          hash_done;
  logic [HW-1:0] hash_value;
  logic          begin_hash;
  logic          quit_hash;
  logic [NW-1:0] nonce;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic [CW-1:0] attempt_cnt;
  logic          timeout_err;

  int vectors    = 0;
  int miscompares = 0;

  nonce_search_ctrl #(
    .NONCE_W(NW), .HASH_W(HW), .CNT_W(CW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start_search(start_search), .stop_search(stop_search),
    .nonce_base(nonce_base), .target(target), .hash_done(hash_done), .hash_value(hash_value),
    .begin_hash(begin_hash), .quit_hash(quit_hash), .nonce(nonce), .busy(busy),
    .found(found), .exhausted(exhausted), .attempt_cnt(attempt_cnt), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [HW-1:0] rand256();
    logic [HW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Emulates the hashing controller: answers each begin_hash after lat cycles with the next digest.
  task automatic drive_search(input logic [NW-1:0] base, input logic [HW-1:0] tgt,
                              input dig_q_t dig, input int lat,
                              output int begins, output nonce_q_t begin_nonces,
                              output bit timed_out);
    int pending;
    int idx;
    begins = 0; begin_nonces = {}; pending = -1; idx = 0; timed_out = 1'b1;
    nonce_base = base; target = tgt; start_search = 1'b1;
    @(negedge clk);
    start_search = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      hash_done  = 1'b0;
      hash_value = rand256();
      #1;
      if (!busy) begin timed_out = 1'b0; break; end
      if (begin_hash) begin
        begins++;
        begin_nonces.push_back(nonce);
        pending = lat;
      end
      if (pending == 0) begin
        hash_done  = 1'b1;
        hash_value = (idx < dig.size()) ? dig[idx] : {HW{1'b1}};
        idx++;
        pending = -1;
      end else if (pending > 0) begin
        pending--;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({begin_hash, quit_hash, busy, found, exhausted, timeout_err} !== 6'b0 ||
        nonce !== '0 || attempt_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_state: flags=%b nonce=%h cnt=%0d, required all zero",
               {begin_hash, quit_hash, busy, found, exhausted, timeout_err}, nonce, attempt_cnt);
    end
    n_rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || begin_hash !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b begin_hash=%b, required 0/0", busy, begin_hash);
    end
    $display("reset: done");
  endtask

  task automatic test_first_hit();
    int b; nonce_q_t bn; bit to; int late_begins;
    drive_search(32'd5, {HW{1'b1}}, '{256'd0}, $urandom_range(1, 4), b, bn, to);
    vectors++;
    if (to || b != 1 || bn[0] !== 32'd5) begin
      miscompares++;
      $display("FAIL first_hit_begins: timeout=%0b begins=%0d, required 1 begin at nonce 5", to, b);
    end
    vectors++;
    if (found !== 1'b1 || nonce !== 32'd5 || attempt_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL first_hit_result: found=%b nonce=%0d cnt=%0d, required 1/5/1", found, nonce, attempt_cnt);
    end
    late_begins = 0;
    repeat (4) begin @(negedge clk); #1; if (begin_hash) late_begins++; end
    vectors++;
    if (late_begins != 0 || found !== 1'b1) begin
      miscompares++;
      $display("FAIL first_hit_sticky: extra begins=%0d found=%b, required 0/1", late_begins, found);
    end
    $display("first_hit: begins=%0d nonce=%0d cnt=%0d", b, nonce, attempt_cnt);
  endtask

  task automatic test_third_hit();
    int b; nonce_q_t bn; bit to;
    drive_search(32'd0, 256'h10, '{256'h20, 256'h10, 256'h0F}, 2, b, bn, to);
    vectors++;
    if (to || b != 3) begin
      miscompares++;
      $display("FAIL third_hit_begins: timeout=%0b begins=%0d, required 3", to, b);
    end
    vectors++;
    if (found !== 1'b1 || nonce !== 32'd2 || attempt_cnt !== 32'd3) begin
      miscompares++;
      $display("FAIL third_hit_result: found=%b nonce=%0d cnt=%0d, required 1/2/3", found, nonce, attempt_cnt);
    end
    $display("third_hit: begins=%0d nonce=%0d cnt=%0d", b, nonce, attempt_cnt);
  endtask

  task automatic test_exhaust();
    int b; nonce_q_t bn; bit to;
    drive_search(32'hFFFF_FFFE, 256'h10, '{{HW{1'b1}}, 256'h10}, 1, b, bn, to);
    vectors++;
    if (to || b != 2) begin
      miscompares++;
      $display("FAIL exhaust_begins: timeout=%0b begins=%0d, required 2", to, b);
    end
    vectors++;
    if (exhausted !== 1'b1 || found !== 1'b0 || nonce !== 32'hFFFF_FFFF || attempt_cnt !== 32'd2) begin
      miscompares++;
      $display("FAIL exhaust_result: exh=%b found=%b nonce=%h cnt=%0d, required 1/0/ffffffff/2",
               exhausted, found, nonce, attempt_cnt);
    end
    $display("exhaust: begins=%0d nonce=%h cnt=%0d", b, nonce, attempt_cnt);
  endtask

  task automatic test_stop_with_done();
    int quits = 0;
    nonce_base = 32'd7; target = '0; start_search = 1'b1;
    @(negedge clk); start_search = 1'b0;              // LAUNCH nonce 7
    @(negedge clk); hash_done = 1'b1; hash_value = 256'h5;  // WAIT_HASH
    @(negedge clk); hash_done = 1'b0;                 // COMPARE
    @(negedge clk);                                   // LAUNCH nonce 8
    @(negedge clk); hash_done = 1'b1; stop_search = 1'b1; // WAIT_HASH, stop wins
    #1;
    if (quit_hash) quits++;
    vectors++;
    if (quit_hash !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_quit_pulse: quit_hash=%b, required 1", quit_hash);
    end
    @(negedge clk); hash_done = 1'b0; stop_search = 1'b0;
    #1;
    if (quit_hash) quits++;
    vectors++;
    if (busy !== 1'b0 || found !== 1'b0 || quits != 1 || attempt_cnt !== 32'd1 || nonce !== 32'd8) begin
      miscompares++;
      $display("FAIL stop_result: busy=%b found=%b quits=%0d cnt=%0d nonce=%0d, required 0/0/1/1/8",
               busy, found, quits, attempt_cnt, nonce);
    end
    $display("stop_with_done: quits=%0d nonce=%0d cnt=%0d", quits, nonce, attempt_cnt);
  endtask

  task automatic test_async_reset();
    int b; nonce_q_t bn; bit to;
    nonce_base = 32'd3; target = '0; start_search = 1'b1;
    @(negedge clk); start_search = 1'b0;
    @(negedge clk);                                   // WAIT_HASH
    #2 n_rst = 1'b0;
    #1;
    vectors++;
    if ({begin_hash, quit_hash, busy, found, exhausted, timeout_err} !== 6'b0 ||
        nonce !== '0 || attempt_cnt !== '0) begin
      miscompares++;
      $display("FAIL async_reset: flags=%b nonce=%h cnt=%0d, required all zero",
               {begin_hash, quit_hash, busy, found, exhausted, timeout_err}, nonce, attempt_cnt);
    end
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
    drive_search(32'h100, {HW{1'b1}}, '{256'd1}, 3, b, bn, to);
    vectors++;
    if (to || b != 1 || bn[0] !== 32'h100 || found !== 1'b1 || nonce !== 32'h100) begin
      miscompares++;
      $display("FAIL async_reset_restart: begins=%0d found=%b nonce=%h, required 1/1/100", b, found, nonce);
    end
    $display("async_reset: restart nonce=%h", nonce);
  endtask

  task automatic test_stop_in_found();
    stop_search = 1'b1;
    #1;
    vectors++;
    if (quit_hash !== 1'b0) begin
      miscompares++;
      $display("FAIL found_stop_quit: quit_hash=%b, required 0", quit_hash);
    end
    @(negedge clk); stop_search = 1'b0;
    #1;
    vectors++;
    if (found !== 1'b0 || exhausted !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL found_stop_clear: found=%b exh=%b busy=%b, required 0/0/0", found, exhausted, busy);
    end
    $display("stop_in_found: cleared");
  endtask

`ifdef HASH_TIMEOUT_EN
  task automatic test_timeout();
    int fires = 0; int fire_at = -1; int rebegin = -1; int bad_nonce = 0; int bad_quit = 0;
    nonce_base = 32'd9; target = '0; start_search = 1'b1;
    @(negedge clk); start_search = 1'b0;              // cycle 0: LAUNCH
    for (int c = 0; c < 14; c++) begin
      #1;
      if (timeout_err) begin
        fires++;
        if (fire_at < 0) fire_at = c;
        if (!quit_hash) bad_quit++;
      end
      if (begin_hash) begin
        if (c > 0 && rebegin < 0) rebegin = c;
        if (nonce !== 32'd9) bad_nonce++;
      end
      @(negedge clk);
    end
    vectors++;
    if (fires != 1 || fire_at != 9 || bad_quit != 0) begin
      miscompares++;
      $display("FAIL timeout_fire: fires=%0d at=%0d badquit=%0d, required 1 at cycle 9 with quit", fires, fire_at, bad_quit);
    end
    vectors++;
    if (rebegin != 10 || bad_nonce != 0 || attempt_cnt !== '0) begin
      miscompares++;
      $display("FAIL timeout_retry: rebegin=%0d badnonce=%0d cnt=%0d, required 10/0/0", rebegin, bad_nonce, attempt_cnt);
    end
    stop_search = 1'b1;
    @(negedge clk); stop_search = 1'b0;
    $display("timeout: fire_at=%0d rebegin=%0d", fire_at, rebegin);
  endtask
`endif

  task automatic test_random_searches();
    for (int t = 0; t < 25; t++) begin
      logic [NW-1:0] base;
      logic [HW-1:0] tgt;
      dig_q_t dig;
      int n; int b; nonce_q_t bn; bit to;
      bit exp_found; int exp_n; int bad_seq;
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      tgt = rand256() >> $urandom_range(0, 200);
      if (tgt == '0) tgt = 256'd1;
      n = $urandom_range(1, 6);
      dig = {};
      for (int i = 0; i < n - 1; i++) dig.push_back(rand256() >> $urandom_range(0, 200));
      dig.push_back(tgt >> $urandom_range(1, 8));
      // Reference: the first digest below target wins, unless the top nonce is reached first.
      exp_found = 1'b0; exp_n = 0;
      for (int i = 0; i < dig.size(); i++) begin
        if (dig[i] < tgt) begin exp_found = 1'b1; exp_n = i + 1; break; end
        if (64'(base) + 64'(i) == 64'hFFFF_FFFF) begin exp_n = i + 1; break; end
      end
      drive_search(base, tgt, dig, $urandom_range(1, 4), b, bn, to);
      bad_seq = 0;
      foreach (bn[k]) if (bn[k] !== base + NW'(k)) bad_seq++;
      vectors++;
      if (to || b != exp_n || bad_seq != 0) begin
        miscompares++;
        $display("FAIL rand_begins[%0d]: begins=%0d badseq=%0d timeout=%0b, required %0d/0/0", t, b, bad_seq, to, exp_n);
      end
      vectors++;
      if (found !== exp_found || exhausted !== !exp_found ||
          nonce !== base + NW'(exp_n - 1) || attempt_cnt !== CW'(exp_n)) begin
        miscompares++;
        $display("FAIL rand_result[%0d]: found=%b exh=%b nonce=%h cnt=%0d, required %b/%b/%h/%0d", t,
                 found, exhausted, nonce, attempt_cnt, exp_found, !exp_found, base + NW'(exp_n - 1), exp_n);
      end
      $display("random[%0d]: base=%h attempts=%0d found=%b", t, base, b, found);
    end
  endtask

  initial begin
    n_rst = 1'b0; start_search = 1'b0; stop_search = 1'b0;
    nonce_base = '0; target = '0; hash_done = 1'b0; hash_value = '0;
    @(negedge clk);
    test_reset();
    test_first_hit();
    test_third_hit();
    test_exhaust();
    test_stop_with_done();
    test_async_reset();
    test_stop_in_found();
`ifdef HASH_TIMEOUT_EN
    test_timeout();
`endif
    test_random_searches();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
